// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared AES definitions: S-box lookups, Rcon, GF(2^8) helpers and FSM states
// for the iterative inverse cipher.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_NR    = 10;

    typedef enum logic [1:0] {
        KEY_EMPTY,
        KEY_EXP,
        IDLE,
        DEC
    } state_t;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last is set, InvMixColumns.
module inv_round
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state,
    input  logic [AES_BLK_W-1:0] round_key,
    input  logic                 last,
    output logic [AES_BLK_W-1:0] result
);

    logic [7:0] ark [16];

    function automatic logic [7:0] mix(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return gf_mul(a, 8'h0e) ^ gf_mul(b, 8'h0b) ^ gf_mul(c, 8'h0d) ^ gf_mul(d, 8'h09);
    endfunction

    // Byte k = 4*col+row; row r takes its byte from column (c - r) mod 4.
    always_comb begin
        ark = '{default: '0};
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                ark[4*c+r] = inv_sbox(state[AES_BLK_W-1-8*(4*((c+4-r)%4)+r) -: 8])
                           ^ round_key[AES_BLK_W-1-8*(4*c+r) -: 8];
            end
        end
    end

    always_comb begin
        result = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                if (last)
                    result[AES_BLK_W-1-8*(4*c+r) -: 8] = ark[4*c+r];
                else
                    result[AES_BLK_W-1-8*(4*c+r) -: 8] = mix(ark[4*c+r], ark[4*c+(r+1)%4],
                                                             ark[4*c+(r+2)%4], ark[4*c+(r+3)%4]);
            end
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher with on-chip key expansion and round-key store.
// Optional INV_CIPHER_CLEAR_OUT_EN zeroes plain_text outside the valid_out pulse.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int DATA_W    = AES_BLK_W,
    parameter int KEY_L     = AES_BLK_W,
    parameter int NO_ROUNDS = AES_NR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cipherkey_valid_in,
    input  logic [KEY_L-1:0]  cipher_key,
    input  logic              data_valid_in,
    input  logic [DATA_W-1:0] cipher_text,
    output logic              ready_out,
    output logic              key_ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] plain_text
);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         rnd;
    logic [DATA_W-1:0]  blk;
    logic [KEY_L-1:0]   rk [0:NO_ROUNDS];
    logic [KEY_L-1:0]   prev_key;
    logic [31:0]        rot_sub;
    logic [KEY_L-1:0]   key_next;
    logic [DATA_W-1:0]  round_out;

    assign ready_out = (state == IDLE) && !cipherkey_valid_in;

    inv_round u_inv_round (
        .state     (blk),
        .round_key (rk[rnd]),
        .last      (rnd == '0),
        .result    (round_out)
    );

    // rk[rnd] doubles as the previous round key during expansion.
    always_comb begin
        prev_key = rk[rnd];
        rot_sub  = {sbox(prev_key[23:16]), sbox(prev_key[15:8]),
                    sbox(prev_key[7:0]),   sbox(prev_key[31:24])} ^ {RCON[rnd], 24'h0};
        key_next[127:96] = prev_key[127:96] ^ rot_sub;
        key_next[95:64]  = prev_key[95:64]  ^ key_next[127:96];
        key_next[63:32]  = prev_key[63:32]  ^ key_next[95:64];
        key_next[31:0]   = prev_key[31:0]   ^ key_next[63:32];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            KEY_EMPTY: if (cipherkey_valid_in) state_nxt = KEY_EXP;
            KEY_EXP:   if (rnd == 4'(NO_ROUNDS-1)) state_nxt = IDLE;
            IDLE: begin
                if (cipherkey_valid_in)  state_nxt = KEY_EXP;
                else if (data_valid_in)  state_nxt = DEC;
            end
            DEC:       if (rnd == '0) state_nxt = IDLE;
            default:   state_nxt = KEY_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= KEY_EMPTY;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rnd           <= '0;
            blk           <= '0;
            key_ready_out <= 1'b0;
            valid_out     <= 1'b0;
            plain_text    <= '0;
            for (int unsigned i = 0; i <= NO_ROUNDS; i++) rk[i] <= '0;
        end else begin
            key_ready_out <= (state_nxt == KEY_EMPTY) || (state_nxt == IDLE);
            valid_out     <= 1'b0;
`ifdef INV_CIPHER_CLEAR_OUT_EN
            plain_text    <= '0;
`endif
            case (state)
                KEY_EMPTY, IDLE: begin
                    if (cipherkey_valid_in) begin
                        rk[0] <= cipher_key;
                        rnd   <= '0;
                    end else if (state == IDLE && data_valid_in) begin
                        blk <= cipher_text ^ rk[NO_ROUNDS];
                        rnd <= 4'(NO_ROUNDS-1);
                    end
                end
                KEY_EXP: begin
                    rk[rnd + 4'd1] <= key_next;
                    rnd            <= rnd + 4'd1;
                end
                DEC: begin
                    if (rnd != '0) begin
                        blk <= round_out;
                        rnd <= rnd - 4'd1;
                    end else begin
                        plain_text <= round_out;
                        valid_out  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: byte-level AES reference model
// with a per-cycle compare process plus directed FIPS-197 vectors.
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         reset;
    logic         ck_valid;
    logic [127:0] key;
    logic         dv;
    logic [127:0] ct;
    logic         ready_out;
    logic         key_ready_out;
    logic         valid_out;
    logic [127:0] plain_text;

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.DATA_W(128), .KEY_L(128), .NO_ROUNDS(10)) dut (
        .clk                (clk),
        .reset              (reset),
        .cipherkey_valid_in (ck_valid),
        .cipher_key         (key),
        .data_valid_in      (dv),
        .cipher_text        (ct),
        .ready_out          (ready_out),
        .key_ready_out      (key_ready_out),
        .valid_out          (valid_out),
        .plain_text         (plain_text)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] aes_dec(input logic [127:0] cin, input logic [127:0] k);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] n [16];
        logic [7:0] t [4];
        logic [7:0] rc;
        logic [7:0] tmp;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = cin[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-4+j];
            if (i % 16 == 0) begin
                tmp = t[0];
                t[0] = sb[t[1]] ^ rc;
                t[1] = sb[t[2]];
                t[2] = sb[t[3]];
                t[3] = sb[tmp];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[160+i];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    n[4*c+r] = isb[s[4*((c-r+4)%4)+r]] ^ w[16*rd+4*c+r];
            for (int c = 0; c < 4; c++) begin
                if (rd > 0) begin
                    s[4*c+0] = gmul(n[4*c],8'h0e)^gmul(n[4*c+1],8'h0b)^gmul(n[4*c+2],8'h0d)^gmul(n[4*c+3],8'h09);
                    s[4*c+1] = gmul(n[4*c],8'h09)^gmul(n[4*c+1],8'h0e)^gmul(n[4*c+2],8'h0b)^gmul(n[4*c+3],8'h0d);
                    s[4*c+2] = gmul(n[4*c],8'h0d)^gmul(n[4*c+1],8'h09)^gmul(n[4*c+2],8'h0e)^gmul(n[4*c+3],8'h0b);
                    s[4*c+3] = gmul(n[4*c],8'h0b)^gmul(n[4*c+1],8'h0d)^gmul(n[4*c+2],8'h09)^gmul(n[4*c+3],8'h0e);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = n[4*c+r];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Cycle model: busy countdowns for key expansion and decryption.
    int           m_bk = 0;
    int           m_bd = 0;
    bit           m_have = 0;
    logic [127:0] m_key = '0;
    logic [127:0] m_pend = '0;
    logic         e_valid = 1'b0;
    logic         e_kr = 1'b0;
    logic [127:0] e_pt = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_have = 0; m_bk = 0; m_bd = 0;
            e_valid = 1'b0; e_pt = '0; e_kr = 1'b0;
        end else begin
            e_valid = 1'b0;
`ifdef INV_CIPHER_CLEAR_OUT_EN
            e_pt = '0;
`endif
            if (m_bk > 0) begin
                m_bk--;
                if (m_bk == 0) m_have = 1;
            end else if (m_bd > 0) begin
                m_bd--;
                if (m_bd == 0) begin
                    e_valid = 1'b1;
                    e_pt = m_pend;
                end
            end else if (ck_valid) begin
                m_key = key; m_bk = 10; m_have = 0;
            end else if (m_have && dv) begin
                m_pend = aes_dec(ct, m_key); m_bd = 10;
            end
            e_kr = (m_bk == 0 && m_bd == 0);
        end
    end

    always @(posedge clk) begin
        #1;
        check("valid_out", 128'(valid_out), 128'(e_valid));
        check("key_ready_out", 128'(key_ready_out), 128'(e_kr));
        check("ready_out", 128'(ready_out),
              128'(m_have && m_bk == 0 && m_bd == 0 && !ck_valid));
        check("plain_text", plain_text, e_pt);
    end

    logic [127:0] pq [$];
    int           pc [$];
    always @(posedge clk) begin
        #1;
        if (valid_out === 1'b1) begin
            pq.push_back(plain_text);
            pc.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_key(input logic [127:0] k, output int e);
        ck_valid = 1'b1;
        key = k;
        @(posedge clk);
        #1 e = cyc;
        @(negedge clk);
        ck_valid = 1'b0;
    endtask

    task automatic send(input logic [127:0] c, output int acc);
        bit done;
        done = 0;
        acc = -1;
        dv = 1'b1;
        ct = c;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (ready_out === 1'b1) begin
                @(posedge clk);
                #1 acc = cyc;
                done = 1;
            end
            @(negedge clk);
        end
        dv = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout actual=not_ready expected=ready");
        end
    endtask

    task automatic wait_pulse(input int n_before, input logic [127:0] exp, input int acc,
                              input string name);
        for (int i = 0; i < 40 && pq.size() <= n_before; i++) @(negedge clk);
        if (pq.size() <= n_before) begin
            errors++;
            $display("FAIL %s_timeout actual=no_pulse expected=pulse", name);
        end else begin
            check(name, pq[n_before], exp);
            check({name, "_latency"}, 128'(pc[n_before] - acc), 128'(10));
        end
    endtask

    initial begin
        int a, a1, a2, e, n;
        reset = 1'b1; ck_valid = 1'b0; dv = 1'b0; key = '0; ct = '0;
        build_tables();
        check("model_sbox0", 128'(sb[0]), 128'h63);
        check("model_vec0", aes_dec(C0, K0), P0);
        check("model_vec1", aes_dec(C1, K1), P1);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_key_ready", 128'(key_ready_out), 128'(0));
        check("rst_ready", 128'(ready_out), 128'(0));
        check("rst_plain", plain_text, '0);
        @(negedge clk);
        check("rst_key_ready_after", 128'(key_ready_out), 128'(1));

        load_key(K0, e);
        n = pq.size(); send(C0, a);
        check("keyload_to_accept", 128'(a - e), 128'(11));
        wait_pulse(n, P0, a, "vec0");

        load_key(K1, e);
        n = pq.size(); send(C1, a); wait_pulse(n, P1, a, "vec1");
        n = pq.size(); send(C1, a); wait_pulse(n, P1, a, "vec1_again");

        n = pq.size();
        send(C1, a); send(C0, a1); send(C1, a2);
        for (int i = 0; i < 40 && pq.size() < n + 3; i++) @(negedge clk);
        if (pq.size() < n + 3) begin
            errors++;
            $display("FAIL b2b_timeout actual=%0d expected=3", pq.size() - n);
        end else begin
            check("b2b_pt0", pq[n], P1);
            check("b2b_pt1", pq[n+1], aes_dec(C0, K1));
            check("b2b_pt2", pq[n+2], P1);
            check("b2b_gap1", 128'(pc[n+1] - pc[n]), 128'(11));
            check("b2b_gap2", 128'(pc[n+2] - pc[n+1]), 128'(11));
        end

        ck_valid = 1'b1; key = K0; dv = 1'b1; ct = C0;
        #1 check("collide_ready", 128'(ready_out), 128'(0));
        @(posedge clk);
        #1 e = cyc;
        @(negedge clk);
        ck_valid = 1'b0;
        n = pq.size(); send(C0, a);
        check("collide_accept", 128'(a - e), 128'(11));
        wait_pulse(n, P0, a, "collide_vec0");

        send(C0, a);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = pq.size();
        repeat (15) @(negedge clk);
        check("abort_no_valid", 128'(pq.size()), 128'(n));
        check("abort_plain", plain_text, '0);
        check("abort_ready", 128'(ready_out), 128'(0));

        load_key(K1, e);
        n = pq.size(); send(C1, a);
        repeat (3) @(negedge clk);
        ck_valid = 1'b1; key = K0;
        @(negedge clk);
        ck_valid = 1'b0;
        wait_pulse(n, P1, a, "midkey_vec1");
        repeat (2) @(negedge clk);
`ifdef INV_CIPHER_CLEAR_OUT_EN
        check("hold_plain", plain_text, '0);
`else
        check("hold_plain", plain_text, P1);
`endif
        n = pq.size(); send(C1, a); wait_pulse(n, P1, a, "oldkey_kept");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 inverse cipher (FIPS 197 §5.3). It decrypts one 128-bit block in 10 round cycles using a single shared inverse-round datapath, and sits on the receive side opposite the pipelined encryption core. The block expands the cipher key into an internal 11×128 round-key store once per key load, then serves any number of decryptions with a valid/ready handshake.

## Interface
- `DATA_W`, 128, block width; only 128 is supported.
- `KEY_L`, 128, key length; only 128 is supported.
- `NO_ROUNDS`, 10, number of rounds.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cipherkey_valid_in`  in  1  request to load `cipher_key`.
- `cipher_key`  in  128  cipher key, FIPS byte order (byte 0 in [127:120]).
- `data_valid_in`  in  1  ciphertext block valid.
- `cipher_text`  in  128  ciphertext block.
- `ready_out`  out  1  combinational: `(state==IDLE) && !cipherkey_valid_in`.
- `key_ready_out`  out  1  registered; high when a key load will be accepted (KEY_EMPTY or IDLE).
- `valid_out`  out  1  one-cycle pulse; `plain_text` is valid.
- `plain_text`  out  128  decrypted block.

## Operation
- FSM states:
  - KEY_EMPTY (reset state).
  - KEY_EXP (10 cycles).
  - IDLE.
  - DEC (10 cycles).
- KEY_EMPTY/IDLE with `cipherkey_valid_in`=1: latch `cipher_key` as w[0], clear the round counter, go to KEY_EXP.
- KEY_EXP: each cycle computes round key k from k−1 (RotWord, SubWord with the forward S-box, Rcon[k]). After k=10 is written, go to IDLE.
- IDLE: a block is accepted when `data_valid_in && ready_out`.
  - On acceptance: state reg ← `cipher_text` ^ w[10]; round counter ← 9; go to DEC.
- DEC, counter r = 9..1: state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), w[r])).
- DEC, r = 0: `plain_text` ← InvSubBytes(InvShiftRows(state)) ^ w[0]; pulse `valid_out`; return to IDLE.
- Key and data requested together in IDLE: key wins. `ready_out` is 0, so the data is not accepted.
- `cipherkey_valid_in` during KEY_EXP or DEC is ignored. The in-flight operation completes with the old key.
- `data_valid_in` outside IDLE is ignored; it is never queued.
- All arithmetic is in GF(2^8) with polynomial 0x11B. InvMixColumns multiplies by 0x0e/0x0b/0x0d/0x09 via repeated xtime.

## Timing
- Reset values:
  - state KEY_EMPTY.
  - `ready_out` 0, `key_ready_out` 0 for one cycle, then 1.
  - `valid_out` 0, `plain_text` 0.
  - Round-key store cleared.
- Key load: accepting edge E, then IDLE after edge E+10. `ready_out` can first be 1 in the cycle after edge E+10.
- Decrypt latency: accepting edge A, `valid_out`=1 in the cycle after edge A+10. `ready_out` returns to 1 in that same cycle.
- Maximum throughput: one block per 11 cycles.
- Reset asserted mid-KEY_EXP or mid-DEC: the operation is aborted, the key is invalidated (KEY_EMPTY), and no `valid_out` is produced.

## Configuration
- `INV_CIPHER_CLEAR_OUT_EN`
  - Defined: `plain_text` is forced to 0 in every cycle where `valid_out` is 0, so plaintext is visible only during the pulse.
  - Undefined: `plain_text` holds the last result until the next completion or reset.

## Structure
- Package `aes_pkg` contains:
  - Forward and inverse S-box constant functions.
  - Rcon table.
  - `xtime` and `gf_mul` functions.
  - FSM state enum.
  - Constants `AES_BLK_W`=128 and `AES_NR`=10.
- Sub-module `inv_round` (combinational): inputs are state, round key and `last` flag; output is the next state. When `last` is set, InvMixColumns is bypassed.
- The top level holds the FSM, round counter, key-expansion logic and round-key store.

## Test plan
- Key `000102030405060708090a0b0c0d0e0f`, ct `69c4e0d86a7b0430d8cdb78070b4c55a` → pt `00112233445566778899aabbccddeeff`, with `valid_out` exactly 10 edges after acceptance.
- Key `2b7e151628aed2a6abf7158809cf4f3c`, ct `3925841d02dc09fbdc118597196a0b32` → pt `3243f6a8885a308d313198a2e0370734`. Then re-decrypt with no key reload → same result.
- `data_valid_in` held high back-to-back for 3 blocks → 3 pulses 11 cycles apart; `ready_out` is 0 throughout DEC.
- Key load and data presented in the same IDLE cycle → the key is taken, the data is not accepted, and `ready_out` is 0. After the 10 expansion cycles, the data decrypts correctly under the new key.
- Reset asserted at DEC cycle 5 → no `valid_out`; state is KEY_EMPTY; `plain_text`=0; `ready_out` stays 0 until a key is loaded.
- `cipherkey_valid_in` pulsed mid-DEC → ignored; the current block completes with the old key.
- Output hold checks:
  - With `INV_CIPHER_CLEAR_OUT_EN`: `plain_text`=0 the cycle after the pulse.
  - Without it: `plain_text` holds the result.
